// File: rtl/rpg_pkg.sv
// Shared types, default LFSR constants and the Galois step function for the
// multi-channel random pulse generator.
package rpg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } ch_state_t;

  localparam logic [15:0] RPG_DEF_TAPS = 16'hB400;
  localparam logic [15:0] RPG_DEF_SEED = 16'hACE1;
  localparam int          RPG_MAX_W    = 32;

  // Computed at the widest supported width; callers truncate to LFSR_W.
  function automatic logic [RPG_MAX_W-1:0] lfsr_step(
    input logic [RPG_MAX_W-1:0] q,
    input logic [RPG_MAX_W-1:0] taps
  );
    return (q >> 1) ^ (q[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/rpg_channel.sv
// One pulse channel: IDLE/PULSE/HOLD FSM with a shared down-counter for the
// pulse length and the hold-off interval.
module rpg_channel
  import rpg_pkg::*;
#(
  parameter int PW_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_trig,
  input  logic [PW_W-1:0] i_pulse_len,
  input  logic [PW_W-1:0] i_holdoff,
  output logic            o_pulse,
  output logic            o_start
);

  ch_state_t       r_state, w_state_next;
  logic [PW_W-1:0] r_cnt, w_cnt_next;
  logic            r_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pulse <= (w_state_next == PULSE);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    o_start      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_trig) begin
          w_state_next = PULSE;
          w_cnt_next   = i_pulse_len;
          o_start      = 1'b1;
        end
      end
      PULSE: begin
        if (r_cnt == '0) begin
          if (i_holdoff == '0) begin
            w_state_next = IDLE;
          end else begin
            w_state_next = HOLD;
            w_cnt_next   = i_holdoff;
          end
        end else begin
          w_cnt_next = r_cnt - PW_W'(1);
        end
      end
      HOLD: begin
        // The counter holds the number of HOLD cycles still to spend, this one included.
        if (r_cnt <= PW_W'(1)) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - PW_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/random_pulse_gen_mc.sv
// Shared Galois LFSR feeding N_CH pulse channels; optional saturating pulse
// counter built only when RPG_PULSE_COUNT_EN is defined.
module random_pulse_gen_mc
  import rpg_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter int                N_CH   = 4,
  parameter int                PW_W   = 4,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(RPG_DEF_TAPS),
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(RPG_DEF_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_val,
  input  logic [7:0]        threshold,
  input  logic [PW_W-1:0]   pulse_len,
  input  logic [PW_W-1:0]   holdoff,
  output logic [N_CH-1:0]   pulse_out,
  output logic [LFSR_W-1:0] lfsr_q,
  output logic [15:0]       pulse_count
);

  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_lfsr_step;
  logic [N_CH-1:0]   w_trig;
  logic [N_CH-1:0]   w_start;

  assign w_lfsr_step = LFSR_W'(lfsr_step(RPG_MAX_W'(r_lfsr), RPG_MAX_W'(TAPS)));

  // A zero seed would lock the LFSR, so it is replaced by SEED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else if (seed_load) begin
      r_lfsr <= (seed_val == '0) ? SEED : seed_val;
    end else if (ena) begin
      r_lfsr <= w_lfsr_step;
    end
  end

  assign lfsr_q = r_lfsr;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [7:0] w_byte;

      // Low byte of r_lfsr rotated left by 3*gi.
      for (gj = 0; gj < 8; gj++) begin : g_bit
        assign w_byte[gj] = r_lfsr[(gj + LFSR_W - 3*gi) % LFSR_W];
      end

      assign w_trig[gi] = ena && (w_byte < threshold);

      rpg_channel #(
        .PW_W (PW_W)
      ) u_channel (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_trig      (w_trig[gi]),
        .i_pulse_len (pulse_len),
        .i_holdoff   (holdoff),
        .o_pulse     (pulse_out[gi]),
        .o_start     (w_start[gi])
      );
    end
  endgenerate

`ifdef RPG_PULSE_COUNT_EN
  logic [15:0] r_count;
  logic [16:0] w_sum;

  always_comb begin
    w_sum = {1'b0, r_count};
    for (int i = 0; i < N_CH; i++) begin
      w_sum = w_sum + 17'(w_start[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
  end

  assign pulse_count = r_count;
`else
  logic w_unused_start;
  assign w_unused_start = ^w_start;
  assign pulse_count    = 16'h0000;
`endif

endmodule

// File: tb/tb_random_pulse_gen_mc.sv
// Directed bench for random_pulse_gen_mc: a scoreboard queues the expected
// width of every pulse as it starts and checks it when the pulse ends.
module tb_random_pulse_gen_mc;

  localparam int N_CH = 4;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b0;
  logic            ena       = 1'b0;
  logic            seed_load = 1'b0;
  logic [15:0]     seed_val  = 16'h0000;
  logic [7:0]      threshold = 8'd0;
  logic [3:0]      pulse_len = 4'd0;
  logic [3:0]      holdoff   = 4'd0;
  logic [N_CH-1:0] pulse_out;
  logic [15:0]     lfsr_q;
  logic [15:0]     pulse_count;

  always #5 clk = ~clk;

  random_pulse_gen_mc #(
    .LFSR_W (16),
    .N_CH   (N_CH),
    .PW_W   (4),
    .TAPS   (16'hB400),
    .SEED   (16'hACE1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .seed_load   (seed_load),
    .seed_val    (seed_val),
    .threshold   (threshold),
    .pulse_len   (pulse_len),
    .holdoff     (holdoff),
    .pulse_out   (pulse_out),
    .lfsr_q      (lfsr_q),
    .pulse_count (pulse_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] q);
    return {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
  endfunction

  bit              mon_en      = 1'b0;
  bit              ena_off     = 1'b0;
  int              exp_pl      = 0;
  int              min_gap     = 0;
  int              total_runs  = 0;
  int              late_starts = 0;
  int              exp_w [N_CH][$];
  int              run_len [N_CH];
  int              gap_len [N_CH];
  bit              seen_fall [N_CH];
  logic [N_CH-1:0] prev_pulse = '0;

  // Run-length monitor, sampling 2 time units after each rising edge.
  always @(posedge clk) begin
    int e;
    #2;
    if (mon_en) begin
      for (int c = 0; c < N_CH; c++) begin
        if (pulse_out[c] && !prev_pulse[c]) begin
          total_runs++;
          if (ena_off) late_starts++;
          if (seen_fall[c])
            check($sformatf("gap_ch%0d", c),
                  32'((gap_len[c] >= min_gap) ? min_gap : gap_len[c]), 32'(min_gap));
          exp_w[c].push_back(exp_pl + 1);
          run_len[c] = 1;
        end else if (pulse_out[c]) begin
          run_len[c]++;
        end else if (prev_pulse[c]) begin
          e = (exp_w[c].size() != 0) ? exp_w[c].pop_front() : -1;
          check($sformatf("width_ch%0d", c), 32'(run_len[c]), 32'(e));
          seen_fall[c] = 1'b1;
          gap_len[c]   = 1;
        end else begin
          gap_len[c]++;
        end
      end
      prev_pulse = pulse_out;
    end
  end

  initial begin
    logic [15:0] model;
    logic [15:0] rec;
    int          highs;
    int          zeros;
    int          ret;
    int          exp_cnt;
    bit          got;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_lfsr",  32'(lfsr_q),      32'hACE1);
    check("rst_pulse", 32'(pulse_out),   32'h0);
    check("rst_count", 32'(pulse_count), 32'h0);

    rst_n = 1'b1;
    ena   = 1'b1;
    @(negedge clk);
    check("first_step", 32'(lfsr_q), 32'hE270);

    // Seed load, including the zero-seed substitution
    seed_load = 1'b1;
    seed_val  = 16'h0000;
    @(negedge clk);
    check("seed_zero", 32'(lfsr_q), 32'hACE1);
    seed_val = 16'h1234;
    @(negedge clk);
    check("seed_1234", 32'(lfsr_q), 32'h1234);
    seed_load = 1'b0;

    // threshold = 0: never fires; LFSR tracks the reference model
    model = 16'h1234;
    highs = 0;
    repeat (1000) begin
      @(negedge clk);
      model = model_step(model);
      if (pulse_out != '0) highs++;
    end
    check("thr0_highs", 32'(highs),       32'h0);
    check("thr0_lfsr",  32'(lfsr_q),      32'(model));
    check("thr0_count", 32'(pulse_count), 32'h0);

    // Width 3, gap >= 6 on every channel
    pulse_len = 4'd2;
    holdoff   = 4'd5;
    exp_pl    = 2;
    min_gap   = 6;
    threshold = 8'd255;
    mon_en    = 1'b1;
    repeat (400) @(negedge clk);
    ena = 1'b0;
    repeat (30) @(negedge clk);
    check("pw_runs_seen", 32'((total_runs >= 150) ? 1 : 0), 32'h1);
`ifdef RPG_PULSE_COUNT_EN
    exp_cnt = total_runs;
`else
    exp_cnt = 0;
`endif
    check("pw_count", 32'(pulse_count), 32'(exp_cnt));

    // ena dropped mid-pulse; pulse_len/holdoff changed mid-pulse too
    pulse_len = 4'd4;
    holdoff   = 4'd2;
    exp_pl    = 4;
    min_gap   = 3;
    ena       = 1'b1;
    got       = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (pulse_out[0]) got = 1'b1;
    end
    check("ena_wait_pulse", 32'(got), 32'h1);
    ena         = 1'b0;
    ena_off     = 1'b1;
    pulse_len   = 4'd0;
    holdoff     = 4'd0;
    rec         = lfsr_q;
    late_starts = 0;
    repeat (20) @(negedge clk);
    check("ena_lfsr_hold", 32'(lfsr_q),      32'(rec));
    check("ena_no_new",    32'(late_starts), 32'h0);
    check("ena_idle",      32'(pulse_out),   32'h0);
`ifdef RPG_PULSE_COUNT_EN
    exp_cnt = total_runs;
`else
    exp_cnt = 0;
`endif
    check("ena_count", 32'(pulse_count), 32'(exp_cnt));

    // Asynchronous reset in the middle of a pulse
    mon_en    = 1'b0;
    ena_off   = 1'b0;
    pulse_len = 4'd15;
    ena       = 1'b1;
    got       = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (pulse_out != '0) got = 1'b1;
    end
    check("arst_pulse_seen", 32'(got), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pulse", 32'(pulse_out),   32'h0);
    check("arst_lfsr",  32'(lfsr_q),      32'hACE1);
    check("arst_count", 32'(pulse_count), 32'h0);

    // Full period from SEED, never zero
    @(negedge clk);
    threshold = 8'd0;
    rst_n     = 1'b1;
    zeros     = 0;
    ret       = 0;
    for (int k = 1; k <= 70000 && ret == 0; k++) begin
      @(negedge clk);
      if (lfsr_q == 16'h0000) zeros++;
      if (lfsr_q == 16'hACE1) ret = k;
    end
    check("period",  32'(ret),   32'd65535);
    check("no_zero", 32'(zeros), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
